// File: rtl/relu_maxpool_pkg.sv
// Shared definitions for the windowed pooling/conv blocks: FSM encoding,
// output-dimension and counter-width helpers.
package relu_maxpool_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    POOL = 2'd2,
    DONE = 2'd3
  } pool_state_t;

  function automatic int out_dim(input int n_in, input int n_win, input int stride);
    return ((n_in - n_win) / stride) + 1;
  endfunction

  // Bits needed to index n entries (0..n-1); never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_max_acc.sv
// Running-maximum register for one pooling window; inputs are post-ReLU,
// so an unsigned compare is sufficient.
module pool_max_acc #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         load,
  input  logic         update,
  input  logic [W-1:0] din,
  output logic [W-1:0] max_next
);

  logic [W-1:0] acc_q;

  // Strict greater-than keeps the held value on ties.
  always_comb begin
    max_next = acc_q;
    if (load) begin
      max_next = din;
    end else if (update && (din > acc_q)) begin
      max_next = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clk_en) begin
      acc_q <= max_next;
    end
  end

endmodule

// File: rtl/relu_maxpool.sv
// ReLU followed by sliding-window max pooling over a flat feature map,
// one window element per enabled cycle.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | capture X with ReLU into the input bank
// POOL  | walk windows, one element per enabled cycle
// DONE  | Y holds the full result, done asserted
module relu_maxpool
  import relu_maxpool_pkg::*;
#(
  parameter int In_d_W = 18,
  parameter int R_I    = 3,
  parameter int C_I    = 3,
  parameter int R_P    = 2,
  parameter int C_P    = 2,
  parameter int S_P    = 1,
  localparam int R_Q   = out_dim(R_I, R_P, S_P),
  localparam int C_Q   = out_dim(C_I, C_P, S_P)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        start,
  input  logic [R_I*C_I*In_d_W-1:0]   X,
  output logic                        busy,
  output logic                        done,
  output logic [R_Q*C_Q*In_d_W-1:0]   Y
);

  localparam int N_I      = R_I * C_I;
  localparam int N_Q      = R_Q * C_Q;
  localparam int POOL_LEN = N_Q * R_P * C_P;

  localparam int IW  = cnt_w(N_I);
  localparam int QW  = cnt_w(N_Q);
  localparam int QRW = cnt_w(R_Q);
  localparam int QCW = cnt_w(C_Q);
  localparam int WRW = cnt_w(R_P);
  localparam int WCW = cnt_w(C_P);
  localparam int PW  = cnt_w(POOL_LEN);

  localparam logic [QRW-1:0] QR_LAST  = QRW'(R_Q - 1);
  localparam logic [QCW-1:0] QC_LAST  = QCW'(C_Q - 1);
  localparam logic [WRW-1:0] WR_LAST  = WRW'(R_P - 1);
  localparam logic [WCW-1:0] WC_LAST  = WCW'(C_P - 1);
  localparam logic [PW-1:0]  POOL_TOP = PW'(POOL_LEN - 1);

  pool_state_t state, state_nxt;

  logic [In_d_W-1:0] in_bank  [N_I];
  logic [In_d_W-1:0] res_bank [N_Q];

  logic [QRW-1:0] qr;
  logic [QCW-1:0] qc;
  logic [WRW-1:0] wr;
  logic [WCW-1:0] wc;
  logic [PW-1:0]  pool_cnt;

  logic [IW-1:0]     elem_idx;
  logic [QW-1:0]     q_idx;
  logic [In_d_W-1:0] elem;
  logic [In_d_W-1:0] max_next;
  logic              win_first, win_last, pool_tc;
  logic [N_Q*In_d_W-1:0] y_nxt;

  function automatic logic [In_d_W-1:0] relu(input logic [In_d_W-1:0] v);
    return v[In_d_W-1] ? '0 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = POOL;
      POOL:    if (pool_tc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    elem_idx  = IW'((int'(qr) * S_P + int'(wr)) * C_I + int'(qc) * S_P + int'(wc));
    q_idx     = QW'(int'(qr) * C_Q + int'(qc));
    elem      = in_bank[elem_idx];
    win_first = (wr == '0) && (wc == '0);
    win_last  = (wr == WR_LAST) && (wc == WC_LAST);
    pool_tc   = (pool_cnt == '0);
  end

  // The final window's maximum is still in flight on the last POOL edge,
  // so it is merged here to let Y be complete while done is high.
  always_comb begin
    y_nxt = '0;
    for (int q = 0; q < N_Q; q++) begin
      y_nxt[q*In_d_W +: In_d_W] = (win_last && (q_idx == QW'(q))) ? max_next : res_bank[q];
    end
  end

  pool_max_acc #(
    .W (In_d_W)
  ) u_max_acc (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .load     ((state == POOL) && win_first),
    .update   ((state == POOL) && !win_first),
    .din      (elem),
    .max_next (max_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      qr       <= '0;
      qc       <= '0;
      wr       <= '0;
      wc       <= '0;
      pool_cnt <= '0;
      Y        <= '0;
      for (int k = 0; k < N_I; k++) in_bank[k] <= '0;
      for (int q = 0; q < N_Q; q++) res_bank[q] <= '0;
    end else if (clk_en) begin
      case (state)
        LOAD: begin
          for (int k = 0; k < N_I; k++) in_bank[k] <= relu(X[k*In_d_W +: In_d_W]);
          qr       <= '0;
          qc       <= '0;
          wr       <= '0;
          wc       <= '0;
          pool_cnt <= POOL_TOP;
        end
        POOL: begin
          if (win_last) res_bank[q_idx] <= max_next;
          if (pool_tc) begin
            Y <= y_nxt;
          end else begin
            pool_cnt <= pool_cnt - 1'b1;
          end
          if (wc == WC_LAST) begin
            wc <= '0;
            if (wr == WR_LAST) begin
              wr <= '0;
              if (qc == QC_LAST) begin
                qc <= '0;
                qr <= (qr == QR_LAST) ? '0 : qr + 1'b1;
              end else begin
                qc <= qc + 1'b1;
              end
            end else begin
              wr <= wr + 1'b1;
            end
          end else begin
            wc <= wc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench for relu_maxpool at default parameters: stimulus queues
// the expected Y, a monitor compares on each done pulse.
module tb_relu_maxpool;

  localparam int W  = 18;
  localparam int XW = 9 * W;
  localparam int YW = 4 * W;

  logic          clk = 1'b0;
  logic          rst, clk_en, start;
  logic [XW-1:0] X;
  logic          busy, done;
  logic [YW-1:0] Y;

  int checks = 0;
  int errors = 0;
  int done_events = 0;
  logic [YW-1:0] exp_q[$];

  always #5 clk = ~clk;

  relu_maxpool dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .start  (start),
    .X      (X),
    .busy   (busy),
    .done   (done),
    .Y      (Y)
  );

  task automatic check(input string name, input logic [YW-1:0] act, input logic [YW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [XW-1:0] pack_x(input int v[9]);
    logic [XW-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*W +: W] = W'(v[k]);
    return r;
  endfunction

  function automatic logic [YW-1:0] pack_y(input int v[4]);
    logic [YW-1:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*W +: W] = W'(v[k]);
    return r;
  endfunction

  initial begin : monitor
    logic          done_prev;
    logic [YW-1:0] exp_y;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        done_events++;
        check("expected_pending", YW'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_y = exp_q.pop_front();
          check("y_on_done", Y, exp_y);
        end
      end
      done_prev = done;
    end
  end

  // One full operation; with stall, clk_en alternates 0,1,... starting
  // with a disabled edge, so start is accepted on the second edge.
  task automatic run_op(input logic [XW-1:0] xv, input logic [YW-1:0] yv,
                        input bit stall, input int exp_done_n, input int exp_busy_n);
    int n, done_n, busy_n;
    X = xv;
    exp_q.push_back(yv);
    start  = 1'b1;
    clk_en = stall ? 1'b0 : 1'b1;
    n = 0; done_n = 0; busy_n = 0;
    while (done_n == 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (busy) start = 1'b0;
      if (stall) clk_en = (n % 2 == 1);
      @(negedge clk);
      if (busy) busy_n++;
      if (done) done_n = n;
    end
    check("done_latency", YW'(done_n), YW'(exp_done_n));
    check("busy_cycles", YW'(busy_n), YW'(exp_busy_n));
    clk_en = 1'b1;
    start  = 1'b0;
    @(posedge clk); #1;
    check("busy_after_done", YW'(busy), 0);
    check("done_one_cycle", YW'(done), 0);
  endtask

  initial begin : stimulus
    int xa[9];
    int ya[4];
    logic [XW-1:0] x_seq, x_neg, x_mix;
    logic [YW-1:0] y_seq, y_zero, y_mix;
    int n, done_n, ev0;

    xa = '{1, 2, 3, 4, 5, 6, 7, 8, 9};                        x_seq = pack_x(xa);
    xa = '{-7, -7, -7, -7, -7, -7, -7, -7, -7};               x_neg = pack_x(xa);
    xa = '{-1, 200, -3, 4, -5, 6, 131071, -131072, 0};        x_mix = pack_x(xa);
    ya = '{5, 6, 8, 9};                                       y_seq = pack_y(ya);
    ya = '{0, 0, 0, 0};                                       y_zero = pack_y(ya);
    ya = '{200, 200, 131071, 6};                              y_mix = pack_y(ya);

    rst = 1'b1; clk_en = 1'b0; start = 1'b1; X = x_seq;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", YW'(busy), 0);
    check("reset_done", YW'(done), 0);
    check("reset_y", Y, 0);
    rst = 1'b0; start = 1'b0; clk_en = 1'b1;
    @(posedge clk); #1;

    run_op(x_seq, y_seq, 1'b0, 18, 18);
    run_op(x_neg, y_zero, 1'b0, 18, 18);
    run_op(x_mix, y_mix, 1'b0, 18, 18);
    run_op(x_seq, y_seq, 1'b1, 36, 35);

    // Reset at POOL cycle 7 aborts the run with no done.
    ev0 = done_events;
    X = x_seq; start = 1'b1; n = 0;
    while (n < 8) begin
      @(posedge clk); #1;
      n++;
      if (busy) start = 1'b0;
    end
    check("busy_before_abort", YW'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", YW'(busy), 0);
    check("abort_done", YW'(done), 0);
    check("abort_y", Y, 0);
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_done", YW'(done_events), YW'(ev0));
    run_op(x_mix, y_mix, 1'b0, 18, 18);

    // Starts during POOL and DONE are ignored; mid-run X changes have no effect.
    ev0 = done_events;
    X = x_seq; exp_q.push_back(y_seq); start = 1'b1; n = 0; done_n = 0;
    while (done_n == 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (n == 6) begin
        start = 1'b1;
        X = x_neg;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) done_n = n;
    end
    check("ignored_start_latency", YW'(done_n), 18);
    start = 1'b1; X = x_mix;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_at_done_busy", YW'(busy), 0);
    repeat (25) @(posedge clk);
    #1;
    check("single_done", YW'(done_events - ev0), 1);
    check("y_held", Y, y_seq);
    check("queue_drained", YW'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/relu_maxpool.md
RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 The module SHALL have parameter In_d_W, default 18: width of each conv result element, two's complement.
REQ-002 The module SHALL have parameter R_I, default 3: rows of the input feature map.
REQ-003 The module SHALL have parameter C_I, default 3: columns of the input feature map.
REQ-004 The module SHALL have parameter R_P, default 2: pooling window rows.
REQ-005 The module SHALL have parameter C_P, default 2: pooling window columns.
REQ-006 The module SHALL have parameter S_P, default 1: pooling stride.
REQ-007 The module SHALL derive R_Q=((R_I-R_P)/S_P)+1 and C_Q=((C_I-C_P)/S_P)+1, which are 2 and 2 at the defaults.
REQ-008 The module SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-009 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 The module SHALL have port clk_en, input, 1 bit: global clock enable that qualifies every register update.
REQ-011 The module SHALL have port start, input, 1 bit: request to pool the current X.
REQ-012 The module SHALL have port X, input, R_I*C_I*In_d_W bits: flat feature map, element k=r*C_I+c at bits [(k+1)*In_d_W-1 : k*In_d_W].
REQ-013 The module SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-014 The module SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-015 The module SHALL have port Y, output, R_Q*C_Q*In_d_W bits: pooled map, same flat packing with C_Q columns.

Function
REQ-016 The module SHALL use the FSM states IDLE, LOAD, POOL and DONE, and SHALL evaluate every transition only on edges where clk_en=1.
REQ-017 The FSM SHALL move IDLE->LOAD when start=1; start SHALL be ignored in every other state.
REQ-018 The LOAD state SHALL capture X into an internal bank for one cycle, apply ReLU per element (negative becomes 0, non-negative passes), and then move to POOL.
REQ-019 The POOL state SHALL process one window element per enabled cycle: output index q in raster order, then window row and column in raster order, covering element (qr*S_P+wr, qc*S_P+wc).
REQ-020 The running maximum SHALL load on the first element of each window, update as max(running, element) on later elements, and write into result slot q on the last element.
REQ-021 POOL SHALL last exactly R_Q*C_Q*R_P*C_P enabled cycles (16 at the defaults) and then move to DONE.
REQ-022 The DONE state SHALL copy the result bank to Y, assert done for one enabled cycle, and move to IDLE.
REQ-023 Y SHALL hold its value from done until the next DONE and SHALL never show partial results.
REQ-024 Latency from the start-accept edge to the done-high cycle SHALL be R_Q*C_Q*R_P*C_P+2 enabled cycles, which is 18 at the defaults.
REQ-025 busy SHALL be 1 in LOAD, POOL and DONE, and 0 in IDLE.
REQ-026 When clk_en=0, the state, counters, banks, Y and done SHALL all hold; a held done SHALL stay high until the next enabled edge.
REQ-027 All comparisons SHALL be unsigned after ReLU, the MSB of every Y element SHALL always be 0, and there SHALL be no width growth.
REQ-028 A start that coincides with DONE SHALL be ignored; the module SHALL be restarted from IDLE.
REQ-029 Equal values SHALL give a deterministic maximum (equal values are interchangeable).

Reset
REQ-030 When rst=1 at an edge, the module SHALL go to IDLE, clear counters, banks and Y to 0, and drive busy=0 and done=0, regardless of clk_en or state.
REQ-031 A reset during POOL SHALL abort the operation with no done pulse; the next start SHALL run a full operation.

Structure
REQ-032 A shared package SHALL hold the output-dimension functions for R_Q and C_Q, the FSM state encoding, and a counter-width helper (clog2), shared with slide-window conv users.
REQ-033 The module SHALL contain one sub-module, pool_max_acc: running-max register with load, update and clk_en inputs.

Verification
REQ-034 The bench SHALL drive X = 1..9 (row-major), then start -> done at cycle 18, Y = {5,6,8,9}, with busy high for cycles 1-18.
REQ-035 The bench SHALL drive X = all -7 (negative) -> Y = {0,0,0,0}.
REQ-036 The bench SHALL drive X = {-1,200,-3,4,-5,6,131071,-131072,0} -> Y = {200,200,131071,6}.
REQ-037 The bench SHALL toggle clk_en 0/1 every cycle during a run -> done at enabled-cycle 18 (wall cycle 36), with the same Y as the no-stall run.
REQ-038 The bench SHALL assert rst at POOL cycle 7 -> no done, Y=0, busy=0; then start again -> correct Y after 18 cycles.
REQ-039 The bench SHALL pulse start at POOL cycle 5 and at DONE -> both ignored, exactly one done, and Y unchanged by the later X.
